// File: rtl/tetris_board_ctrl.sv
// Tetris playfield owner: probe/lock collision test, vblank-deferred write and line clear. Option: BOARD_LINE_TOTAL_EN.
// Latency: read port 1 cycle; PROBE done 5 cycles after accept; LOCK done after vblank wait + 4 check + 4 write + scan/shift.
// Backpressure: o_cmd_ready only in IDLE, so one command is in flight; the read port is never stalled.
module tetris_board_ctrl #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int CELL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sync_va,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_op,
    input  logic [35:0]       i_cmd_cells,
    input  logic [3:0]        i_cmd_color,
    output logic              o_done,
    output logic              o_collide,
    output logic [2:0]        o_lines,
    input  logic [3:0]        i_rd_x,
    input  logic [4:0]        i_rd_y,
    output logic [CELL_W-1:0] o_rd_cell,
    output logic [15:0]       o_line_total
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_VB = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_SCAN    = 3'd4;
    localparam logic [2:0] S_SHIFT   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [3:0] COLS_X = 4'(COLS);
    localparam logic [4:0] ROWS_Y = 5'(ROWS);
    localparam logic [4:0] ROW_BOT = 5'(ROWS - 1);

    logic [2:0]        state;
    logic              live;
    logic              op_q;
    logic [8:0]        cells_q [4];
    logic [CELL_W-1:0] color_q;
    logic [1:0]        idx_q;
    logic              coll_q;
    logic [4:0]        row_q;
    logic [2:0]        lines_q;
    logic [CELL_W-1:0] board [ROWS][COLS];

    logic [8:0] cur;
    logic [3:0] cur_x;
    logic [4:0] cur_y;
    logic       cur_in;
    logic       cur_hit;
    logic       coll_nxt;
    logic       row_full;
    logic       scan_fin;

    always_comb begin
        cur     = cells_q[idx_q];
        cur_x   = cur[8:5];
        cur_y   = cur[4:0];
        cur_in  = (cur_x < COLS_X) && (cur_y < ROWS_Y);
        cur_hit = 1'b1;
        if (cur_in) cur_hit = (board[cur_y][cur_x] != '0);
        coll_nxt = coll_q | cur_hit;
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (board[row_q][c] == '0) row_full = 1'b0;
        end
        scan_fin = (state == S_SCAN) && !row_full && (row_q == 5'd0);
    end

    assign o_cmd_ready = live && (state == S_IDLE);
    assign o_done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            live      <= 1'b0;
            op_q      <= 1'b0;
            color_q   <= '0;
            idx_q     <= 2'd0;
            coll_q    <= 1'b0;
            row_q     <= 5'd0;
            lines_q   <= 3'd0;
            o_collide <= 1'b0;
            o_lines   <= 3'd0;
            for (int k = 0; k < 4; k++) cells_q[k] <= 9'd0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        op_q    <= i_cmd_op;
                        for (int k = 0; k < 4; k++) cells_q[k] <= i_cmd_cells[9*k +: 9];
                        color_q <= (i_cmd_color == 4'd0) ? CELL_W'(1) : CELL_W'(i_cmd_color);
                        idx_q   <= 2'd0;
                        coll_q  <= 1'b0;
                        lines_q <= 3'd0;
                        row_q   <= ROW_BOT;
                        state   <= i_cmd_op ? S_WAIT_VB : S_CHECK;
                    end
                end
                S_WAIT_VB: if (!i_sync_va) state <= S_CHECK;
                S_CHECK: begin
                    coll_q <= coll_nxt;
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (!op_q || coll_nxt) begin
                            o_collide <= coll_nxt;
                            o_lines   <= 3'd0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    board[cur_y][cur_x] <= color_q;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) state <= S_SCAN;
                end
                S_SCAN: begin
                    if (row_full) begin
                        state <= S_SHIFT;
                    end else if (scan_fin) begin
                        o_collide <= 1'b0;
                        o_lines   <= lines_q;
                        state     <= S_DONE;
                    end else begin
                        row_q <= row_q - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // Everything above the full row drops by one; the same row is rescanned next.
                    for (int r = 1; r < ROWS; r++) begin
                        if (5'(r) <= row_q) board[r] <= board[r-1];
                    end
                    for (int c = 0; c < COLS; c++) board[0][c] <= '0;
                    lines_q <= (lines_q == 3'd4) ? 3'd4 : lines_q + 3'd1;
                    state   <= S_SCAN;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rd_cell <= '0;
        end else if ((i_rd_x < COLS_X) && (i_rd_y < ROWS_Y)) begin
            o_rd_cell <= board[i_rd_y][i_rd_x];
        end else begin
            o_rd_cell <= '0;
        end
    end

`ifdef BOARD_LINE_TOTAL_EN
    logic [15:0] total_q;
    logic [16:0] total_sum;
    assign total_sum    = {1'b0, total_q} + {14'd0, lines_q};
    assign o_line_total = total_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= 16'd0;
        end else if (scan_fin) begin
            total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`else
    assign o_line_total = 16'd0;
`endif

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Bench for tetris_board_ctrl: board model with whole-row compaction, per-cycle compare, directed and random commands.
module tb_tetris_board_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_sync_va = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_op = 1'b0;
    logic [35:0] i_cmd_cells = '0;
    logic [3:0]  i_cmd_color = '0;
    logic        o_done;
    logic        o_collide;
    logic [2:0]  o_lines;
    logic [3:0]  i_rd_x = '0;
    logic [4:0]  i_rd_y = '0;
    logic [3:0]  o_rd_cell;
    logic [15:0] o_line_total;

    tetris_board_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_sync_va(i_sync_va),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_cells(i_cmd_cells), .i_cmd_color(i_cmd_color),
        .o_done(o_done), .o_collide(o_collide), .o_lines(o_lines),
        .i_rd_x(i_rd_x), .i_rd_y(i_rd_y), .o_rd_cell(o_rd_cell), .o_line_total(o_line_total)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int va_mode = 1;
    logic rd_hold = 1'b0;

    logic [3:0] mdl [20][10];
    logic [3:0] nxt [20][10];
    logic       busy = 1'b0;
    logic       e_coll, last_coll;
    int         e_lines, last_lines, m_total;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int mread(input int x, input int y);
        if (x < 10 && y < 20) return int'(mdl[y][x]);
        return 0;
    endfunction

    function automatic logic [35:0] pk(input int x0, y0, x1, y1, x2, y2, x3, y3);
        return {4'(x3), 5'(y3), 4'(x2), 5'(y2), 4'(x1), 5'(y1), 4'(x0), 5'(y0)};
    endfunction

    // Reference: occupancy test, paint, then drop every full row at once.
    task automatic model_accept(input logic op, input logic [35:0] cells, input logic [3:0] col);
        int xs[4];
        int ys[4];
        int dst;
        logic full;
        logic [8:0] c;
        logic [3:0] tmp [20][10];
        e_coll = 1'b0;
        for (int k = 0; k < 4; k++) begin
            c = 9'(cells >> (9 * k));
            xs[k] = int'(c[8:5]);
            ys[k] = int'(c[4:0]);
            if (xs[k] >= 10 || ys[k] >= 20) e_coll = 1'b1;
            else if (mdl[ys[k]][xs[k]] != 4'd0) e_coll = 1'b1;
        end
        nxt = mdl;
        e_lines = 0;
        if (op && !e_coll) begin
            for (int k = 0; k < 4; k++) nxt[ys[k]][xs[k]] = (col == 4'd0) ? 4'd1 : col;
            tmp = nxt;
            dst = 19;
            for (int r = 19; r >= 0; r--) begin
                full = 1'b1;
                for (int x = 0; x < 10; x++) if (tmp[r][x] == 4'd0) full = 1'b0;
                if (full) e_lines++;
                else begin
                    nxt[dst] = tmp[r];
                    dst--;
                end
            end
            for (int r = dst; r >= 0; r--)
                for (int x = 0; x < 10; x++) nxt[r][x] = 4'd0;
        end
        if (e_lines > 4) e_lines = 4;
    endtask

    initial begin : compare
        logic rst_prev;
        logic pend_ok;
        int   pend_val;
        logic acc_op;
        rst_prev = 1'b0;
        pend_ok  = 1'b0;
        pend_val = 0;
        acc_op   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_prev) begin
                for (int r = 0; r < 20; r++)
                    for (int x = 0; x < 10; x++) mdl[r][x] = 4'd0;
                busy = 1'b0;
                last_coll = 1'b0;
                last_lines = 0;
                m_total = 0;
                check("rd_in_reset", int'(o_rd_cell), 0);
            end
            check("cmd_ready", int'(o_cmd_ready), int'(rst_prev && !busy));
            if (pend_ok) check("rd_cell", int'(o_rd_cell), pend_val);
            if (o_done) begin
                if (!busy || !rst_prev) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=1 expected=0 t=%0t", $time);
                end else begin
                    check("collide", int'(o_collide), int'(e_coll));
                    check("lines", int'(o_lines), e_lines);
                    mdl = nxt;
                    last_coll = e_coll;
                    last_lines = e_lines;
                    if (acc_op) m_total = (m_total + e_lines > 65535) ? 65535 : m_total + e_lines;
                    busy = 1'b0;
                end
            end else begin
                check("collide_hold", int'(o_collide), int'(last_coll));
                check("lines_hold", int'(o_lines), last_lines);
            end
`ifdef BOARD_LINE_TOTAL_EN
            check("line_total", int'(o_line_total), m_total);
`else
            check("line_total", int'(o_line_total), 0);
`endif
            if (rst_n && i_cmd_valid && o_cmd_ready) begin
                model_accept(i_cmd_op, i_cmd_cells, i_cmd_color);
                acc_op = i_cmd_op;
                busy = 1'b1;
            end
            pend_val = mread(int'(i_rd_x), int'(i_rd_y));
            pend_ok  = rst_n && !busy;
            rst_prev = rst_n;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (va_mode == 2) begin
            if ($urandom_range(15) == 0) i_sync_va = !i_sync_va;
        end else begin
            i_sync_va = (va_mode != 0);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (!rd_hold) begin
            i_rd_x = 4'($urandom_range(15));
            i_rd_y = 5'($urandom_range(31));
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        i_cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rd(input int x, input int y, output int v);
        rd_hold = 1'b1;
        @(posedge clk); #1;
        i_rd_x = 4'(x);
        i_rd_y = 5'(y);
        @(posedge clk); #1;
        v = int'(o_rd_cell);
        rd_hold = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [35:0] cells, input logic [3:0] col, output logic ok);
        @(posedge clk); #1;
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_cells = cells;
        i_cmd_color = col;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (o_cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd_op = 1'($urandom);
        i_cmd_cells = 36'({$urandom, $urandom});
        i_cmd_color = 4'($urandom);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 expected=1 t=%0t", $time);
        end
    endtask

    task automatic wait_done(input int bound, output logic ok, output int n);
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            n++;
            if (o_done) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 expected=1 t=%0t", $time);
            do_reset(2);
        end
    endtask

    task automatic run(input logic op, input logic [35:0] cells, input logic [3:0] col);
        logic ok;
        int n;
        issue(op, cells, col, ok);
        if (ok) wait_done(400, ok, n);
    endtask

    task automatic prefill_case4();
        run(1'b1, pk(0, 19, 1, 19, 2, 19, 3, 19), 4'd2);
        run(1'b1, pk(4, 19, 5, 19, 0, 18, 0, 18), 4'd2);
    endtask

    initial begin : stim
        logic ok;
        int n, v, dones;
        logic [35:0] cells;

        // 1: reset release, empty board
        do_reset(3);
        @(negedge clk); check("t1_ready_first", int'(o_cmd_ready), 0);
        @(negedge clk); check("t1_ready_next", int'(o_cmd_ready), 1);
        v = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                int r;
                rd(x, y, r);
                v = v | r;
            end
        check("t1_all_zero", v, 0);
        rd(10, 0, v); check("t1_rd_oob", v, 0);

        // 2: probe square on empty board
        va_mode = 1;
        issue(1'b0, pk(4, 0, 5, 0, 4, 1, 5, 1), 4'd6, ok);
        wait_done(50, ok, n);
        check("t2_probe_latency", n, 5);
        check("t2_collide", int'(o_collide), 0);
        rd(4, 0, v); check("t2_rd_4_0", v, 0);

        // 3: lock held off by active video
        issue(1'b1, pk(4, 0, 5, 0, 4, 1, 5, 1), 4'd3, ok);
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check("t3_no_done_in_va", dones, 0);
        rd(5, 1, v); check("t3_rd_before", v, 0);
        va_mode = 0;
        wait_done(100, ok, n);
        check("t3_collide", int'(o_collide), 0);
        check("t3_lines", int'(o_lines), 0);
        rd(5, 1, v); check("t3_rd_5_1", v, 3);

        // 4: single line clear with the row above dropping in
        do_reset(2);
        prefill_case4();
        run(1'b1, pk(6, 19, 7, 19, 8, 19, 9, 19), 4'd5);
        check("t4_lines", int'(o_lines), 1);
        check("t4_collide", int'(o_collide), 0);
`ifdef BOARD_LINE_TOTAL_EN
        check("t4_total", int'(o_line_total), 1);
`endif
        for (int x = 0; x < 10; x++) begin
            rd(x, 19, v);
            check("t4_row19", v, (x == 0) ? 2 : 0);
        end
        rd(0, 18, v); check("t4_row18", v, 0);
        rd(3, 0, v);  check("t4_row0", v, 0);

        // 5: colliding locks leave the board alone
        run(1'b1, pk(10, 5, 0, 0, 1, 0, 2, 0), 4'd7);
        check("t5_oob_collide", int'(o_collide), 1);
        check("t5_oob_lines", int'(o_lines), 0);
        run(1'b1, pk(1, 17, 2, 17, 3, 17, 0, 19), 4'd7);
        check("t5_occ_collide", int'(o_collide), 1);
        rd(1, 17, v); check("t5_rd_1_17", v, 0);
        rd(0, 19, v); check("t5_rd_0_19", v, 2);
        rd(1, 0, v);  check("t5_rd_1_0", v, 0);

        // 6: reset while scanning
        do_reset(2);
        prefill_case4();
        issue(1'b1, pk(6, 19, 7, 19, 8, 19, 9, 19), 4'd5, ok);
        repeat (12) @(posedge clk);
        do_reset(2);
        @(negedge clk); check("t6_ready_first", int'(o_cmd_ready), 0);
        @(negedge clk); check("t6_ready_next", int'(o_cmd_ready), 1);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check("t6_no_done", dones, 0);
        v = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                int r;
                rd(x, y, r);
                v = v | r;
            end
        check("t6_all_zero", v, 0);

        // random traffic
        va_mode = 2;
        for (int t = 0; t < 160; t++) begin
            int sel, x0, y0;
            sel = $urandom_range(7);
            if (sel < 4) begin
                x0 = $urandom_range(6);
                y0 = $urandom_range(19, 12);
                cells = pk(x0, y0, x0 + 1, y0, x0 + 2, y0, x0 + 3, y0);
            end else if (sel < 6) begin
                x0 = $urandom_range(9);
                y0 = $urandom_range(16);
                cells = pk(x0, y0, x0, y0 + 1, x0, y0 + 2, x0, y0 + 3);
            end else begin
                cells = 36'({$urandom, $urandom});
            end
            if ($urandom_range(19) == 0) begin
                issue(1'($urandom_range(3) != 0), cells, 4'($urandom_range(15)), ok);
                repeat ($urandom_range(20)) @(posedge clk);
                do_reset(2);
            end else begin
                run(1'($urandom_range(3) != 0), cells, 4'($urandom_range(15)));
            end
            if ($urandom_range(29) == 0) do_reset(2);
            repeat ($urandom_range(3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
